// File: rtl/ps2_kbd_decoder_pkg.sv
// ps2_kbd_decoder_pkg: shared types, PS/2 set-2 constants and decoder states
package ps2_kbd_decoder_pkg;
  typedef logic [7:0] byte_t;
  typedef struct packed {
    byte_t scancode;
    logic  extended;
    logic  is_break;
  } kbd_event_t;
  localparam byte_t PS2_BREAK    = 8'hF0;
  localparam byte_t PS2_EXT      = 8'hE0;
  localparam byte_t PS2_PAUSE    = 8'hE1;
  localparam byte_t PS2_ACK      = 8'hFA;
  localparam byte_t PS2_RESEND   = 8'hFE;
  localparam byte_t PS2_BAT_OK   = 8'hAA;
  localparam byte_t PS2_BAT_FAIL = 8'hFC;
  localparam byte_t PS2_ECHO     = 8'hEE;
  typedef enum logic [2:0] {IDLE, BRK, EXT, EXT_BRK, PAUSE} state_t;
  // bytes expected after the leading E1 of the Pause sequence, indexed 1..7
  function automatic byte_t pause_byte(input logic [2:0] idx);
    case (idx)
      3'd1: return 8'h14;
      3'd2: return 8'h77;
      3'd3: return 8'hE1;
      3'd4: return 8'hF0;
      3'd5: return 8'h14;
      3'd6: return 8'hF0;
      3'd7: return 8'h77;
      default: return 8'h00;
    endcase
  endfunction
endpackage

// File: rtl/ps2_kbd_decoder_fifo.sv
// kbd_event_fifo: first-word-fall-through event FIFO, DEPTH a power of two
module kbd_event_fifo
  import ps2_kbd_decoder_pkg::*;
#(
  parameter int DEPTH = 8
) (
  input  logic                       clk_i,
  input  logic                       reset_i,
  input  logic                       push,
  input  kbd_event_t                 din,
  input  logic                       pop,
  output kbd_event_t                 dout,
  output logic [$clog2(DEPTH+1)-1:0] count,
  output logic                       full,
  output logic                       empty
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH + 1);
  kbd_event_t mem [DEPTH];
  logic [AW-1:0] wp, rp;
  logic wr, rd;
  assign full  = count == CW'(DEPTH);
  assign empty = count == '0;
  // a full FIFO still accepts a push when the head leaves in the same cycle
  assign wr    = push && (!full || pop);
  assign rd    = pop && !empty;
  assign dout  = empty ? '0 : mem[rp];
  always_ff @(posedge clk_i or posedge reset_i)
    if (reset_i) begin
      wp    <= '0;
      rp    <= '0;
      count <= '0;
    end else begin
      if (wr) wp <= wp + 1'b1;
      if (rd) rp <= rp + 1'b1;
      count <= count + CW'(wr) - CW'(rd);
    end
  always_ff @(posedge clk_i)
    if (wr) mem[wp] <= din;
endmodule

// File: rtl/ps2_kbd_decoder.sv
// ps2_kbd_decoder: PS/2 set-2 byte stream to buffered keyboard events
module ps2_kbd_decoder
  import ps2_kbd_decoder_pkg::*;
#(
  parameter int    DEPTH         = 8,
  parameter bit    FILTER_REPEAT = 1'b1,
  parameter byte_t PAUSE_CODE    = 8'h77
) (
  input  logic                       clk_i,
  input  logic                       reset_i,
  input  byte_t                      data_i,
  input  logic                       valid_i,
  output kbd_event_t                 event_o,
  output logic                       valid_o,
  input  logic                       ready_i,
  output logic [$clog2(DEPTH+1)-1:0] count_o,
  output logic                       overflow_o,
  input  logic                       clear_i,
  output logic                       ack_o,
  output logic                       resend_o,
  output logic                       bat_ok_o,
  output logic                       bat_fail_o,
  output logic                       error_o
);
  state_t state, st_n;
  logic [2:0] cnt, cnt_n;
  logic gen, brk, ext, pause, err, keep, idle_v;
  logic [511:0] pressed;
  logic [8:0] idx;
  kbd_event_t ev;
  logic ev_valid, pop, full, empty;
  assign idle_v = valid_i && state == IDLE;
  assign idx    = {ext, data_i};
  assign keep   = pause || brk || !FILTER_REPEAT || !pressed[idx];
  always_comb begin
    st_n  = state;
    cnt_n = cnt;
    gen   = 1'b0;
    brk   = 1'b0;
    ext   = 1'b0;
    pause = 1'b0;
    err   = 1'b0;
    if (valid_i)
      case (state)
        IDLE: begin
          if (data_i == PS2_BREAK) st_n = BRK;
          else if (data_i == PS2_EXT) st_n = EXT;
          else if (data_i == PS2_PAUSE) begin
            st_n  = PAUSE;
            cnt_n = 3'd1;
          end else if (data_i == 8'h00 || data_i == 8'hFF) err = 1'b1;
          else gen = !(data_i inside {PS2_ACK, PS2_RESEND, PS2_BAT_OK, PS2_BAT_FAIL, PS2_ECHO});
        end
        BRK: begin
          st_n = IDLE;
          err  = data_i == PS2_BREAK || data_i == PS2_EXT;
          gen  = !err;
          brk  = 1'b1;
        end
        EXT: begin
          st_n = data_i == PS2_BREAK ? EXT_BRK : IDLE;
          err  = data_i == PS2_EXT || data_i == PS2_PAUSE;
          gen  = !err && data_i != PS2_BREAK;
          ext  = 1'b1;
        end
        EXT_BRK: begin
          st_n = IDLE;
          err  = data_i == PS2_BREAK || data_i == PS2_EXT;
          gen  = !err;
          ext  = 1'b1;
          brk  = 1'b1;
        end
        PAUSE: begin
          err   = data_i != pause_byte(cnt);
          gen   = !err && cnt == 3'd7;
          pause = gen;
          st_n  = err || gen ? IDLE : PAUSE;
          cnt_n = cnt + 3'd1;
        end
        default: st_n = IDLE;
      endcase
  end
  always_ff @(posedge clk_i or posedge reset_i)
    if (reset_i) begin
      state      <= IDLE;
      cnt        <= '0;
      ev         <= '0;
      ev_valid   <= 1'b0;
      ack_o      <= 1'b0;
      resend_o   <= 1'b0;
      bat_ok_o   <= 1'b0;
      bat_fail_o <= 1'b0;
      error_o    <= 1'b0;
      pressed    <= '0;
    end else begin
      state      <= st_n;
      cnt        <= cnt_n;
      ev_valid   <= gen && keep;
      ev         <= {pause ? PAUSE_CODE : data_i, ext || pause, brk};
      ack_o      <= idle_v && data_i == PS2_ACK;
      resend_o   <= idle_v && data_i == PS2_RESEND;
      bat_ok_o   <= idle_v && data_i == PS2_BAT_OK;
      bat_fail_o <= idle_v && data_i == PS2_BAT_FAIL;
      error_o    <= err;
      // a completed self-test means the keyboard forgot every held key
      if (idle_v && data_i == PS2_BAT_OK) pressed <= '0;
      else if (FILTER_REPEAT && gen && !pause) pressed[idx] <= !brk;
    end
  assign pop     = valid_o && ready_i;
  assign valid_o = !empty;
  always_ff @(posedge clk_i or posedge reset_i)
    if (reset_i) overflow_o <= 1'b0;
    else if (ev_valid && full && !pop) overflow_o <= 1'b1;
    else if (clear_i) overflow_o <= 1'b0;
  kbd_event_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk_i  (clk_i),
    .reset_i(reset_i),
    .push   (ev_valid),
    .din    (ev),
    .pop    (pop),
    .dout   (event_o),
    .count  (count_o),
    .full   (full),
    .empty  (empty)
  );
endmodule
